// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared types and helpers for the configuration-chain loader.
//   - state_e   : loader FSM states (IDLE, RUN, DONE)
//   - num_words : ceiling division, words needed to cover a chain
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned num_words(input int unsigned len, input int unsigned w);
        return (len + w - 1) / w;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_packer.sv
// ccff_rb_packer
//   Serial-to-parallel packer for bits leaving the configuration chain.
//   Bits are packed LSB-first; a word is emitted after WORD_W bits or on
//   the last bit of the chain (zero-padded above the last bit).
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset
//     clear_i        : discard any partial group (new load)
//     bit_i          : sampled chain tail bit
//     strobe_i       : bit_i is valid this cycle
//     last_i         : this strobe carries the final chain bit
//     rb_data_o      : packed readback word (held between pulses)
//     rb_valid_o     : one-cycle pulse qualifying rb_data_o
module ccff_rb_packer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              bit_i,
    input  logic              strobe_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] rb_data_o,
    output logic              rb_valid_o
);

    localparam int unsigned POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] word_w;

    always_comb begin
        acc_d   = acc_q;
        pos_d   = pos_q;
        data_d  = data_q;
        valid_d = 1'b0;
        // Accumulator is cleared after every emission, so bits above the
        // current position are already zero for a partial final group.
        word_w          = acc_q;
        word_w[pos_q]   = bit_i;
        if (clear_i) begin
            acc_d = '0;
            pos_d = '0;
        end else if (strobe_i) begin
            if (pos_q == POS_W'(WORD_W - 1) || last_i) begin
                data_d  = word_w;
                valid_d = 1'b1;
                acc_d   = '0;
                pos_d   = '0;
            end else begin
                acc_d = word_w;
                pos_d = pos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            pos_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rb_data_o  = data_q;
    assign rb_valid_o = valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Loads a configuration chain: accepts bitstream words over valid/ready,
//   serialises them LSB-first onto ccff_head with one chain shift per cycle
//   of chain_clk_en, and packs the displaced ccff_tail bits into readback
//   words.
//   Ports:
//     prog_clk, prog_reset : clock, synchronous active-high reset
//     start                : begin a full chain load (ignored while busy)
//     cfg_data/valid/ready : bitstream word handshake, bit 0 shifted first
//     ccff_head            : serial data into the chain
//     chain_clk_en         : chain clock-gate enable, one shift per cycle
//     ccff_tail            : serial data out of the chain
//     rb_data/rb_valid     : packed readback words
//     busy, done           : load in progress / load complete
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 240,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int unsigned IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned WCNT_W    = $clog2(NUM_WORDS + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              sr_full_q, sr_full_d;
    logic [WORD_W-1:0] hr_q, hr_d;
    logic              hr_full_q, hr_full_d;

    logic shift_w;
    logic sr_free_w;
    logic accept_w;
    logic last_bit_w;
    logic pack_clear_w;

    assign shift_w    = (state_q == ST_RUN) && sr_full_q;
    assign last_bit_w = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    // Words beyond the chain length are never accepted, so the host sees
    // exactly ceil(CHAIN_LEN/WORD_W) handshakes per load.
    assign cfg_ready  = (state_q == ST_RUN) && !hr_full_q && (wcnt_q < WCNT_W'(NUM_WORDS));
    assign accept_w   = cfg_valid && cfg_ready;
    assign sr_free_w  = !sr_full_q || (shift_w && idx_q == IDX_W'(WORD_W - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        sr_d         = sr_q;
        idx_d        = idx_q;
        sr_full_d    = sr_full_q;
        hr_d         = hr_q;
        hr_full_d    = hr_full_q;
        pack_clear_w = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                    wcnt_d       = '0;
                    idx_d        = '0;
                    sr_full_d    = 1'b0;
                    hr_full_d    = 1'b0;
                    pack_clear_w = 1'b1;
                end
            end
            ST_RUN: begin
                if (shift_w) begin
                    cnt_d = cnt_q + 1'b1;
                    idx_d = idx_q + 1'b1;
                end
                if (accept_w) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                // Refill SR in the cycle it empties (HR first, then the
                // incoming word) so consecutive words shift with no bubble.
                if (sr_free_w) begin
                    sr_full_d = 1'b0;
                    if (hr_full_q) begin
                        sr_d      = hr_q;
                        sr_full_d = 1'b1;
                        idx_d     = '0;
                        hr_full_d = 1'b0;
                        if (accept_w) begin
                            hr_d      = cfg_data;
                            hr_full_d = 1'b1;
                        end
                    end else if (accept_w) begin
                        sr_d      = cfg_data;
                        sr_full_d = 1'b1;
                        idx_d     = '0;
                    end
                end else if (accept_w) begin
                    hr_d      = cfg_data;
                    hr_full_d = 1'b1;
                end
                if (shift_w && last_bit_w) begin
                    state_d   = ST_DONE;
                    sr_full_d = 1'b0;
                    hr_full_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            sr_q      <= '0;
            idx_q     <= '0;
            sr_full_q <= 1'b0;
            hr_q      <= '0;
            hr_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            sr_q      <= sr_d;
            idx_q     <= idx_d;
            sr_full_q <= sr_full_d;
            hr_q      <= hr_d;
            hr_full_q <= hr_full_d;
        end
    end

    assign chain_clk_en = shift_w;
    assign ccff_head    = shift_w ? sr_q[idx_q] : 1'b0;
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);

    ccff_rb_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk_i      (prog_clk),
        .rst_i      (prog_reset),
        .clear_i    (pack_clear_w),
        .bit_i      (ccff_tail),
        .strobe_i   (shift_w),
        .last_i     (last_bit_w),
        .rb_data_o  (rb_data),
        .rb_valid_o (rb_valid)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic prog_reset = 1'b1;

    // DUT A: CHAIN_LEN=10, WORD_W=4
    logic       a_start = 1'b0, a_cfg_valid = 1'b0;
    logic [3:0] a_cfg_data = '0;
    logic       a_cfg_ready, a_ccff_head, a_chain_clk_en, a_ccff_tail;
    logic [3:0] a_rb_data;
    logic       a_rb_valid, a_busy, a_done;

    // DUT B: CHAIN_LEN=3, WORD_W=8
    logic       b_start = 1'b0, b_cfg_valid = 1'b0;
    logic [7:0] b_cfg_data = '0;
    logic       b_cfg_ready, b_ccff_head, b_chain_clk_en, b_ccff_tail;
    logic [7:0] b_rb_data;
    logic       b_rb_valid, b_busy, b_done;

    ccff_chain_loader #(.WORD_W(4), .CHAIN_LEN(10)) u_dut_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(a_start),
        .cfg_data(a_cfg_data), .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .ccff_head(a_ccff_head), .chain_clk_en(a_chain_clk_en), .ccff_tail(a_ccff_tail),
        .rb_data(a_rb_data), .rb_valid(a_rb_valid), .busy(a_busy), .done(a_done)
    );

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(3)) u_dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(b_start),
        .cfg_data(b_cfg_data), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .ccff_head(b_ccff_head), .chain_clk_en(b_chain_clk_en), .ccff_tail(b_ccff_tail),
        .rb_data(b_rb_data), .rb_valid(b_rb_valid), .busy(b_busy), .done(b_done)
    );

    // Chain models: bit [N-1] is the deepest DFF driving ccff_tail.
    logic [9:0] a_chain = '0, a_pre = '0;
    logic       a_load = 1'b0;
    logic [2:0] b_chain = '0, b_pre = '0;
    logic       b_load = 1'b0;

    always @(posedge prog_clk) begin
        if (a_load) a_chain <= a_pre;
        else if (a_chain_clk_en) a_chain <= {a_chain[8:0], a_ccff_head};
        if (b_load) b_chain <= b_pre;
        else if (b_chain_clk_en) b_chain <= {b_chain[1:0], b_ccff_head};
    end
    assign a_ccff_tail = a_chain[9];
    assign b_ccff_tail = b_chain[2];

    int vectors = 0;
    int miscompares = 0;

    logic       head_q[$];
    logic [3:0] rb_q[$];
    logic       ready_tr [0:63];

    logic       obs_shift, obs_head, obs_hs, obs_rbv, obs_done, obs_busy;
    logic [3:0] obs_rbd;

    // Capture DUT A's outputs for the current cycle, then advance one cycle.
    task automatic step();
        obs_shift = a_chain_clk_en;
        obs_head  = a_ccff_head;
        obs_hs    = a_cfg_valid && a_cfg_ready;
        obs_rbv   = a_rb_valid;
        obs_rbd   = a_rb_data;
        obs_done  = a_done;
        obs_busy  = a_busy;
        @(posedge prog_clk);
        #1;
    endtask

    function automatic logic [9:0] exp_chain_abc();
        logic [3:0] w [3];
        logic [9:0] c;
        w[0] = 4'hA; w[1] = 4'h5; w[2] = 4'hC;
        c = '0;
        for (int k = 0; k < 10; k++) c[9-k] = w[k/4][k%4];
        return c;
    endfunction

    // One full load of DUT A with words A,5,C (and a 4th word 3 offered).
    task automatic run_load(input logic [9:0] pre, input int gap, input int start_mid,
                            input int rst_shift, output int shifts, output int hs,
                            output int en_runs, output int run1_len, output int done_rise);
        logic [3:0] words [4];
        logic [3:0] w;
        int wi, gap_left, pushed, post;
        logic prev_en, prev_done, rst_now, finished, exp_b;
        logic [3:0] exp_w;
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC; words[3] = 4'h3;
        head_q.delete(); rb_q.delete();
        a_pre = pre; a_load = 1'b1; step(); a_load = 1'b0;
        for (int g = 0; g < 3; g++) begin
            w = '0;
            for (int b = 0; b < 4; b++) if (g*4 + b < 10) w[b] = pre[9 - (g*4 + b)];
            rb_q.push_back(w);
        end
        a_cfg_valid = 1'b0; a_start = 1'b1; step(); a_start = 1'b0;
        shifts = 0; hs = 0; en_runs = 0; run1_len = 0; done_rise = 0;
        wi = 0; gap_left = 0; pushed = 0; post = 0;
        prev_en = 1'b0; prev_done = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            a_cfg_valid = (gap_left == 0) && (wi < 4);
            a_cfg_data  = words[(wi < 4) ? wi : 3];
            a_start     = (cyc == start_mid);
            rst_now     = (rst_shift > 0) && a_chain_clk_en && (shifts == rst_shift - 1);
            prog_reset  = rst_now;
            ready_tr[cyc] = a_cfg_ready;
            step();
            prog_reset = 1'b0; a_start = 1'b0;
            if (obs_hs) begin
                hs++;
                for (int b = 0; b < 4; b++) if (pushed < 10) begin
                    head_q.push_back(words[wi][b]); pushed++;
                end
                if (wi == 0) gap_left = gap;
                wi++;
            end else if (gap_left > 0) gap_left--;
            if (obs_shift) begin
                shifts++;
                if (!prev_en) en_runs++;
                if (en_runs == 1) run1_len++;
                vectors++;
                if (head_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL head_extra: got shift %0d with no expected bit", shifts);
                end else begin
                    exp_b = head_q.pop_front();
                    if (obs_head !== exp_b) begin
                        miscompares++;
                        $display("FAIL head_bit%0d: got %b expected %b", shifts, obs_head, exp_b);
                    end
                end
            end
            prev_en = obs_shift;
            if (obs_rbv) begin
                vectors++;
                if (rb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rb_extra: got rb_data %h with no expected word", obs_rbd);
                end else begin
                    exp_w = rb_q.pop_front();
                    if (obs_rbd !== exp_w) begin
                        miscompares++;
                        $display("FAIL rb_word: got %h expected %h", obs_rbd, exp_w);
                    end
                end
            end
            if (obs_done && !prev_done) begin
                done_rise++;
                vectors++;
                if (shifts !== 10 || obs_busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_timing: got shifts=%0d busy=%b expected 10/0", shifts, obs_busy);
                end
            end
            prev_done = obs_done;
            if (rst_now) begin
                vectors++;
                if ({a_chain_clk_en, a_busy, a_done, a_rb_valid} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL reset_mid: got en/busy/done/rbv=%b expected 0000",
                             {a_chain_clk_en, a_busy, a_done, a_rb_valid});
                end
                finished = 1'b1;
                break;
            end
            if (obs_done) post++;
            if (post >= 3) begin finished = 1'b1; break; end
        end
        a_cfg_valid = 1'b0;
        if (!finished) begin
            vectors++; miscompares++;
            $display("FAIL load_timeout: got no done within 60 cycles expected done");
        end else if (rst_shift == 0) begin
            vectors++;
            if (head_q.size() != 0 || rb_q.size() != 0) begin
                miscompares++;
                $display("FAIL leftover: got %0d head/%0d rb pending expected 0/0",
                         head_q.size(), rb_q.size());
            end
        end
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        a_load = 1'b1; a_pre = '0; b_load = 1'b1; b_pre = '0;
        repeat (3) step();
        a_load = 1'b0; b_load = 1'b0;
        vectors++;
        if ({a_cfg_ready, a_ccff_head, a_chain_clk_en, a_rb_data, a_rb_valid, a_busy, a_done} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_a: got %b expected all zero",
                     {a_cfg_ready, a_ccff_head, a_chain_clk_en, a_rb_data, a_rb_valid, a_busy, a_done});
        end
        vectors++;
        if ({b_cfg_ready, b_ccff_head, b_chain_clk_en, b_rb_data, b_rb_valid, b_busy, b_done} !== 14'b0) begin
            miscompares++;
            $display("FAIL reset_b: got %b expected all zero",
                     {b_cfg_ready, b_ccff_head, b_chain_clk_en, b_rb_data, b_rb_valid, b_busy, b_done});
        end
        prog_reset = 1'b0;
        step();
    endtask

    task automatic test_stream();
        int sh, hs, er, r1, dr;
        run_load(10'b1111100000, 0, -1, 0, sh, hs, er, r1, dr);
        vectors++;
        if (sh !== 10 || er !== 1) begin
            miscompares++;
            $display("FAIL stream_shifts: got %0d shifts in %0d runs expected 10 in 1", sh, er);
        end
        vectors++;
        if (a_chain !== exp_chain_abc()) begin
            miscompares++;
            $display("FAIL stream_chain: got %b expected %b", a_chain, exp_chain_abc());
        end
        vectors++;
        if (a_done !== 1'b1 || dr !== 1) begin
            miscompares++;
            $display("FAIL stream_done: got done=%b rises=%0d expected 1/1", a_done, dr);
        end
    endtask

    task automatic test_underrun();
        int sh, hs, er, r1, dr;
        run_load(10'b0011001110, 5, -1, 0, sh, hs, er, r1, dr);
        vectors++;
        if (sh !== 10 || r1 !== 4 || er !== 2) begin
            miscompares++;
            $display("FAIL underrun_shape: got shifts=%0d first_run=%0d runs=%0d expected 10/4/2", sh, r1, er);
        end
        vectors++;
        if (a_chain !== exp_chain_abc()) begin
            miscompares++;
            $display("FAIL underrun_chain: got %b expected %b", a_chain, exp_chain_abc());
        end
    endtask

    task automatic test_back_pressure();
        int sh, hs, er, r1, dr;
        run_load(10'b0101010101, 0, -1, 0, sh, hs, er, r1, dr);
        vectors++;
        if (hs !== 3) begin
            miscompares++;
            $display("FAIL bp_handshakes: got %0d expected 3", hs);
        end
        vectors++;
        if (ready_tr[1] !== 1'b1 || ready_tr[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready: got cyc1=%b cyc2=%b expected 1/0", ready_tr[1], ready_tr[2]);
        end
    endtask

    task automatic test_reset_mid();
        int sh, hs, er, r1, dr;
        run_load(10'b1100011010, 0, -1, 6, sh, hs, er, r1, dr);
        vectors++;
        if (sh !== 6) begin
            miscompares++;
            $display("FAIL rst_shifts: got %0d expected 6", sh);
        end
        run_load(a_chain, 0, -1, 0, sh, hs, er, r1, dr);
        vectors++;
        if (sh !== 10 || a_chain !== exp_chain_abc()) begin
            miscompares++;
            $display("FAIL reload: got shifts=%0d chain=%b expected 10/%b", sh, a_chain, exp_chain_abc());
        end
    endtask

    task automatic test_start_in_run();
        int sh, hs, er, r1, dr;
        run_load(10'b1010011100, 0, 4, 0, sh, hs, er, r1, dr);
        vectors++;
        if (sh !== 10 || dr !== 1) begin
            miscompares++;
            $display("FAIL start_in_run: got shifts=%0d done_rises=%0d expected 10/1", sh, dr);
        end
    endtask

    task automatic test_short();
        logic       bq[$];
        logic       sh_now, hd_now, rv_now, dn_now, hs_now, exp_b, got_done;
        logic [7:0] rd_now, data, exp_rb;
        int shifts, pulses, hs;
        data = 8'hF5;
        b_pre = 3'b110; b_load = 1'b1; step(); b_load = 1'b0;
        exp_rb = {5'b0, b_pre[0], b_pre[1], b_pre[2]};
        b_start = 1'b1; step(); b_start = 1'b0;
        shifts = 0; pulses = 0; hs = 0; got_done = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            b_cfg_valid = 1'b1; b_cfg_data = data;
            sh_now = b_chain_clk_en; hd_now = b_ccff_head; rv_now = b_rb_valid;
            rd_now = b_rb_data; dn_now = b_done; hs_now = b_cfg_valid && b_cfg_ready;
            step();
            if (hs_now) begin
                hs++;
                if (hs == 1) for (int b = 0; b < 3; b++) bq.push_back(data[b]);
            end
            if (sh_now) begin
                shifts++;
                vectors++;
                exp_b = (bq.size() != 0) ? bq.pop_front() : 1'bx;
                if (hd_now !== exp_b) begin
                    miscompares++;
                    $display("FAIL short_head%0d: got %b expected %b", shifts, hd_now, exp_b);
                end
            end
            if (rv_now) begin
                pulses++;
                vectors++;
                if (rd_now !== exp_rb) begin
                    miscompares++;
                    $display("FAIL short_rb: got %h expected %h", rd_now, exp_rb);
                end
            end
            if (dn_now && !got_done) begin
                got_done = 1'b1;
                vectors++;
                if (shifts !== 3) begin
                    miscompares++;
                    $display("FAIL short_done: got done after %0d shifts expected 3", shifts);
                end
            end
            if (got_done && cyc > 8) break;
        end
        b_cfg_valid = 1'b0;
        vectors++;
        if (!got_done || shifts !== 3 || pulses !== 1 || hs !== 1 || b_chain !== 3'b101) begin
            miscompares++;
            $display("FAIL short_summary: got done=%b shifts=%0d pulses=%0d hs=%0d chain=%b expected 1/3/1/1/101",
                     got_done, shifts, pulses, hs, b_chain);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_underrun();
        test_back_pressure();
        test_reset_mid();
        test_start_in_run();
        test_short();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
